// File: rtl/boot_loader_pkg.sv
// Shared types for the UART boot loader: FSM states, error codes and the default image terminator.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_FRAME    = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_OVERRUN  = 2'b11
  } boot_err_e;

  localparam logic [31:0] END_MARKER_DEF = 32'h0000_0FFF;

endpackage

// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver: synchronizes the pad, times bits from the start edge, emits one-cycle
// byte_valid or frame_err pulses.
module boot_uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e      st;
  logic           rx_q1, rx_q2, rx_q3;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q1        <= 1'b1;
      rx_q2        <= 1'b1;
      rx_q3        <= 1'b1;
      st           <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_valid_o <= 1'b0;
      byte_data_o  <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_q1        <= rx_i;
      rx_q2        <= rx_q1;
      rx_q3        <= rx_q2;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_q3 && !rx_q2) st <= RX_START;
        end
        // Mid-start re-check; a high line here means the edge was a glitch.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_q2 ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_q2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_q2) begin
              byte_valid_o <= 1'b1;
              byte_data_o  <= shreg;
            end else frame_err_o <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot sequencer: packs UART bytes MSB-first into words, writes them to instruction memory,
// and releases the core on the end-of-image marker.
module uart_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          MEM_WORDS    = 16384,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] END_MARKER   = END_MARKER_DEF,
  parameter int          CNT_W        = $clog2(MEM_WORDS) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             uart_rx_i,
  input  logic             boot_en_i,
  output logic             ready_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [3:0]       mem_be_o,
  output logic [CNT_W-1:0] word_count_o,
  output logic             boot_done_o,
  output logic             fetch_enable_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  boot_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (uart_rx_i),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  boot_state_e state;
  boot_err_e   pend_code, wr_err;
  logic        init_q, skid_vld, take;
  logic [7:0]  skid_data, take_byte;
  logic [1:0]  byte_idx;
  logic [31:0] word;

  assign mem_we_o = mem_req_o;
  assign mem_be_o = {4{mem_req_o}};

  always_comb begin
    take      = skid_vld | byte_valid;
    take_byte = skid_vld ? skid_data : byte_data;
    // Errors seen during a write are held until the grant so the request still completes.
    wr_err    = pend_code;
    if (pend_code == ERR_NONE) begin
      if (frame_err)                   wr_err = ERR_FRAME;
      else if (byte_valid && skid_vld) wr_err = ERR_OVERRUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      init_q         <= 1'b0;
      pend_code      <= ERR_NONE;
      skid_vld       <= 1'b0;
      skid_data      <= '0;
      byte_idx       <= '0;
      word           <= '0;
      ready_o        <= 1'b0;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= BASE_ADDR;
      mem_wdata_o    <= '0;
      word_count_o   <= '0;
      boot_done_o    <= 1'b0;
      fetch_enable_o <= 1'b0;
      err_o          <= 1'b0;
      err_code_o     <= ERR_NONE;
    end else begin
      init_q <= 1'b1;
      case (state)
        ST_IDLE: if (init_q) begin
          if (boot_en_i) begin
            state   <= ST_RECV;
            ready_o <= 1'b1;
          end else begin
            state          <= ST_DONE;
            boot_done_o    <= 1'b1;
            fetch_enable_o <= 1'b1;
          end
        end
        ST_RECV: begin
          if (frame_err) begin
            state <= ST_ERR; ready_o <= 1'b0; err_o <= 1'b1; err_code_o <= ERR_FRAME;
          end else if (take) begin
            word     <= {word[23:0], take_byte};
            skid_vld <= skid_vld & byte_valid;
            if (skid_vld && byte_valid) skid_data <= byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state   <= ST_CHECK;
              ready_o <= 1'b0;
            end
          end
        end
        ST_CHECK: begin
          if (frame_err || (byte_valid && skid_vld)) begin
            state <= ST_ERR; err_o <= 1'b1;
            err_code_o <= frame_err ? ERR_FRAME : ERR_OVERRUN;
          end else begin
            if (byte_valid) begin
              skid_vld  <= 1'b1;
              skid_data <= byte_data;
            end
            if (word == END_MARKER) begin
              state <= ST_DONE; boot_done_o <= 1'b1; fetch_enable_o <= 1'b1;
            end else if (word_count_o == CNT_W'(MEM_WORDS)) begin
              state <= ST_ERR; err_o <= 1'b1; err_code_o <= ERR_OVERFLOW;
            end else begin
              state       <= ST_WRITE;
              mem_req_o   <= 1'b1;
              mem_addr_o  <= BASE_ADDR + (32'(word_count_o) << 2);
              mem_wdata_o <= word;
            end
          end
        end
        ST_WRITE: begin
          pend_code <= wr_err;
          if (byte_valid && !skid_vld) begin
            skid_vld  <= 1'b1;
            skid_data <= byte_data;
          end
          if (mem_gnt_i) begin
            mem_req_o    <= 1'b0;
            word_count_o <= word_count_o + 1'b1;
            if (wr_err != ERR_NONE) begin
              state <= ST_ERR; err_o <= 1'b1; err_code_o <= wr_err;
            end else begin
              state   <= ST_RECV;
              ready_o <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERR: ;
        default: state <= ST_ERR;
      endcase
    end
  end

endmodule
